// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the core's single memory port between the debug/boot
//            loader, the load-store unit and instruction fetch. One
//            transaction is in flight at a time (address phase, then
//            response phase). Lost responses time out, and the pipeline is
//            held while an lsu access is pending.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // debug / boot loader
  input  logic            dbg_req_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic            dbg_we_i,
  input  logic [DW-1:0]   dbg_wdata_i,
  input  logic [DW/8-1:0] dbg_be_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic            dbg_err_o,
  // load-store unit
  input  logic            lsu_req_i,
  input  logic [AW-1:0]   lsu_addr_i,
  input  logic            lsu_we_i,
  input  logic [DW-1:0]   lsu_wdata_i,
  input  logic [DW/8-1:0] lsu_be_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic            lsu_err_o,
  // instruction fetch (read-only, full word)
  input  logic            ifu_req_i,
  input  logic [AW-1:0]   ifu_addr_i,
  output logic            ifu_gnt_o,
  output logic            ifu_rvalid_o,
  output logic            ifu_err_o,
  // shared read data
  output logic [DW-1:0]   rdata_o,
  // memory side
  output logic            mem_req_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_we_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  // pipeline / status
  output logic            hold_o,
  output logic            late_rsp_o
);

  localparam int BW = DW / 8;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ADDR = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_DBG  = 2'd1;
  localparam logic [1:0] c_OWN_LSU  = 2'd2;
  localparam logic [1:0] c_OWN_IFU  = 2'd3;

  // The grant cycle counts as the first cycle of waiting, so the response
  // phase gives up in the cycle whose timer value is TIMEOUT-2 (the count
  // would reach TIMEOUT-1 there).
  localparam logic [TW-1:0] c_TMO_LAST   = TW'(TIMEOUT - 2);
  localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [1:0]    r_owner;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [BW-1:0] r_be;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_timer;
  logic          r_late;

  logic [1:0]    w_win;
  logic [AW-1:0] w_win_addr;
  logic          w_win_we;
  logic [DW-1:0] w_win_wdata;
  logic [BW-1:0] w_win_be;
  logic          w_ifu_first;
  logic          w_timeout;
  logic          w_done;

  assign w_ifu_first = (r_starve == c_STARVE_MAX);
  assign w_timeout   = (r_timer == c_TMO_LAST);
  assign w_done      = (r_state == c_DATA) && (mem_rvalid_i || w_timeout);

  // Arbitration: dbg > lsu > ifu, with a starved ifu promoted above lsu.
  always_comb begin
    w_win       = c_OWN_NONE;
    w_win_addr  = '0;
    w_win_we    = 1'b0;
    w_win_wdata = '0;
    w_win_be    = '0;
    if (dbg_req_i) begin
      w_win       = c_OWN_DBG;
      w_win_addr  = dbg_addr_i;
      w_win_we    = dbg_we_i;
      w_win_wdata = dbg_wdata_i;
      w_win_be    = dbg_be_i;
    end else if (ifu_req_i && (w_ifu_first || !lsu_req_i)) begin
      w_win       = c_OWN_IFU;
      w_win_addr  = ifu_addr_i;
      w_win_be    = '1;
    end else if (lsu_req_i) begin
      w_win       = c_OWN_LSU;
      w_win_addr  = lsu_addr_i;
      w_win_we    = lsu_we_i;
      w_win_wdata = lsu_wdata_i;
      w_win_be    = lsu_be_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic: arbitrate, wait for address accept, wait for response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_win != c_OWN_NONE) w_next_state = c_ADDR;
      c_ADDR:  if (mem_gnt_i)           w_next_state = c_DATA;
      c_DATA:  if (w_done)              w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Transaction payload, owner, starvation count, response timer, late flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner  <= c_OWN_NONE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_starve <= '0;
      r_timer  <= '0;
      r_late   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_win != c_OWN_NONE) begin
            r_owner <= w_win;
            r_addr  <= w_win_addr;
            r_we    <= w_win_we;
            r_wdata <= w_win_wdata;
            r_be    <= w_win_be;
          end
          // Only arbitrations that ifu took part in move its starvation count.
          if (ifu_req_i) begin
            if (w_win == c_OWN_IFU)             r_starve <= '0;
            else if (r_starve != c_STARVE_MAX)  r_starve <= r_starve + SW'(1);
          end
        end
        c_ADDR: begin
          if (mem_gnt_i) r_timer <= '0;
        end
        c_DATA: begin
          if (w_done) r_owner <= c_OWN_NONE;
          else        r_timer <= r_timer + TW'(1);
        end
        default: ;
      endcase
      // A response with no transaction waiting for it is dropped but noted.
      if (mem_rvalid_i && (r_state != c_DATA)) r_late <= 1'b1;
    end
  end

  // Outputs: memory payload in the address phase, owner handshakes, hold.
  always_comb begin
    mem_req_o    = (r_state == c_ADDR);
    mem_addr_o   = '0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    dbg_gnt_o    = 1'b0;
    lsu_gnt_o    = 1'b0;
    ifu_gnt_o    = 1'b0;
    dbg_rvalid_o = 1'b0;
    lsu_rvalid_o = 1'b0;
    ifu_rvalid_o = 1'b0;
    dbg_err_o    = 1'b0;
    lsu_err_o    = 1'b0;
    ifu_err_o    = 1'b0;
    rdata_o      = '0;
    if (r_state == c_ADDR) begin
      mem_addr_o  = r_addr;
      mem_we_o    = r_we;
      mem_wdata_o = r_wdata;
      mem_be_o    = r_be;
      if (mem_gnt_i) begin
        dbg_gnt_o = (r_owner == c_OWN_DBG);
        lsu_gnt_o = (r_owner == c_OWN_LSU);
        ifu_gnt_o = (r_owner == c_OWN_IFU);
      end
    end
    if (w_done) begin
      dbg_rvalid_o = (r_owner == c_OWN_DBG);
      lsu_rvalid_o = (r_owner == c_OWN_LSU);
      ifu_rvalid_o = (r_owner == c_OWN_IFU);
      dbg_err_o    = (r_owner == c_OWN_DBG) && !mem_rvalid_i;
      lsu_err_o    = (r_owner == c_OWN_LSU) && !mem_rvalid_i;
      ifu_err_o    = (r_owner == c_OWN_IFU) && !mem_rvalid_i;
      rdata_o      = mem_rvalid_i ? mem_rdata_i : '0;
    end
    hold_o = (lsu_req_i || ((r_owner == c_OWN_LSU) && (r_state != c_IDLE)))
             && !lsu_rvalid_o;
  end

  assign late_rsp_o = r_late;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a
//            transaction-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam int STARVE_MAX = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic dbg_req_i = 0, lsu_req_i = 0, ifu_req_i = 0;
  logic [31:0] dbg_addr_i = 0, lsu_addr_i = 0, ifu_addr_i = 0;
  logic dbg_we_i = 0, lsu_we_i = 0;
  logic [31:0] dbg_wdata_i = 0, lsu_wdata_i = 0;
  logic [3:0] dbg_be_i = 0, lsu_be_i = 0;
  logic dbg_gnt_o, lsu_gnt_o, ifu_gnt_o;
  logic dbg_rvalid_o, lsu_rvalid_o, ifu_rvalid_o;
  logic dbg_err_o, lsu_err_o, ifu_err_o;
  logic [31:0] rdata_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  logic mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic hold_o, late_rsp_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_we_i(dbg_we_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_be_i(dbg_be_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_err_o(dbg_err_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
    .ifu_gnt_o(ifu_gnt_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_err_o(ifu_err_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hold_o(hold_o), .late_rsp_o(late_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 = no transaction, 1 = waiting for address accept,
  //        2 = waiting for response; wait_n = cycles elapsed since the grant.
  int          m_phase = 0;
  int          m_owner = 0;   // 1 dbg, 2 lsu, 3 ifu
  int          m_starve = 0;
  int          m_wait = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic        m_we = 0;
  logic [3:0]  m_be = 0;
  logic        m_late = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase = 0; m_owner = 0; m_starve = 0; m_wait = 0;
      m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0; m_late = 0;
    end else begin
      int w;
      if (mem_rvalid_i && m_phase != 2) m_late = 1'b1;
      case (m_phase)
        0: if (dbg_req_i || lsu_req_i || ifu_req_i) begin
             if (dbg_req_i) w = 1;
             else if (lsu_req_i && !(ifu_req_i && m_starve == STARVE_MAX)) w = 2;
             else w = 3;
             if (ifu_req_i) m_starve = (w == 3) ? 0 : ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve);
             m_owner = w;
             case (w)
               1: begin m_addr = dbg_addr_i; m_we = dbg_we_i; m_wdata = dbg_wdata_i; m_be = dbg_be_i; end
               2: begin m_addr = lsu_addr_i; m_we = lsu_we_i; m_wdata = lsu_wdata_i; m_be = lsu_be_i; end
               default: begin m_addr = ifu_addr_i; m_we = 0; m_wdata = 0; m_be = 4'hF; end
             endcase
             m_phase = 1;
           end
        1: if (mem_gnt_i) begin m_phase = 2; m_wait = 1; end
        default: if (mem_rvalid_i || m_wait == TIMEOUT - 1) begin m_phase = 0; m_owner = 0; end
                 else m_wait++;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic e_done;
  always @(negedge clk_i) begin
    e_done = (m_phase == 2) && (mem_rvalid_i || m_wait == TIMEOUT - 1);
    chk("mem_req",    mem_req_o,    m_phase == 1);
    chk("mem_addr",   mem_addr_o,   (m_phase == 1) ? m_addr : 32'h0);
    chk("mem_we",     mem_we_o,     (m_phase == 1) ? m_we : 1'b0);
    chk("mem_wdata",  mem_wdata_o,  (m_phase == 1) ? m_wdata : 32'h0);
    chk("mem_be",     mem_be_o,     (m_phase == 1) ? m_be : 4'h0);
    chk("dbg_gnt",    dbg_gnt_o,    m_phase == 1 && mem_gnt_i && m_owner == 1);
    chk("lsu_gnt",    lsu_gnt_o,    m_phase == 1 && mem_gnt_i && m_owner == 2);
    chk("ifu_gnt",    ifu_gnt_o,    m_phase == 1 && mem_gnt_i && m_owner == 3);
    chk("dbg_rvalid", dbg_rvalid_o, e_done && m_owner == 1);
    chk("lsu_rvalid", lsu_rvalid_o, e_done && m_owner == 2);
    chk("ifu_rvalid", ifu_rvalid_o, e_done && m_owner == 3);
    chk("dbg_err",    dbg_err_o,    e_done && !mem_rvalid_i && m_owner == 1);
    chk("lsu_err",    lsu_err_o,    e_done && !mem_rvalid_i && m_owner == 2);
    chk("ifu_err",    ifu_err_o,    e_done && !mem_rvalid_i && m_owner == 3);
    chk("rdata",      rdata_o,      (e_done && mem_rvalid_i) ? mem_rdata_i : 32'h0);
    chk("hold",       hold_o,       (lsu_req_i || (m_owner == 2 && m_phase != 0)) && !(e_done && m_owner == 2));
    chk("late_rsp",   late_rsp_o,   m_late);
  end

  // ---------------- memory auto-responder (test 2) ----------------
  logic        auto_mem = 0;
  logic [31:0] rd_seed = 32'h1000_0001;
  always @(posedge clk_i) begin
    logic acc;
    acc = mem_req_o && mem_gnt_i;
    #1;
    if (auto_mem) begin
      mem_rvalid_i = acc;
      mem_rdata_i  = acc ? rd_seed : 32'h0;
      rd_seed      = rd_seed + 32'h0101_0101;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_gnt(output int who);
    who = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (dbg_gnt_o) who = 1;
      else if (lsu_gnt_o) who = 2;
      else if (ifu_gnt_o) who = 3;
      if (who != 0) break;
    end
    if (who == 0) begin
      checks++; errors++;
      $display("FAIL gnt_wait: no grant within 40 cycles, expected one (t=%0t)", $time);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[7];
    int exp_order[7];
    int k;
    int stable_cnt;
    int gcnt;
    exp_order = '{1, 2, 2, 2, 2, 3, 2};

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_hold", hold_o, 1'b0);
    chk("rst_late", late_rsp_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Test 1: single lsu read of 0x100.
    lsu_req_i = 1; lsu_addr_i = 32'h100; lsu_we_i = 0; lsu_be_i = 4'hF;
    @(negedge clk_i);
    chk("t1_hold_c0", hold_o, 1'b1);
    tick();
    mem_gnt_i = 1;
    @(negedge clk_i);
    chk("t1_mem_req", mem_req_o, 1'b1);
    chk("t1_mem_addr", mem_addr_o, 32'h100);
    chk("t1_lsu_gnt", lsu_gnt_o, 1'b1);
    chk("t1_hold_c1", hold_o, 1'b1);
    tick();
    lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("t1_lsu_rvalid", lsu_rvalid_o, 1'b1);
    chk("t1_rdata", rdata_o, 32'hDEADBEEF);
    chk("t1_hold_c2", hold_o, 1'b0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    tick();

    // Test 2: dbg once, lsu and ifu continuously; starvation promotes ifu.
    auto_mem = 1; mem_gnt_i = 1;
    dbg_req_i = 1; dbg_addr_i = 32'hD00; dbg_be_i = 4'hF;
    lsu_req_i = 1; lsu_addr_i = 32'h300; lsu_we_i = 0; lsu_be_i = 4'h3;
    tick();
    ifu_req_i = 1; ifu_addr_i = 32'h400;
    for (int n = 0; n < 7; n++) begin
      wait_gnt(order[n]);
      tick();
      if (order[n] == 1) dbg_req_i = 0;
    end
    lsu_req_i = 0; ifu_req_i = 0;
    for (int n = 0; n < 7; n++) chk($sformatf("t2_order%0d", n), order[n], exp_order[n]);
    tick();
    auto_mem = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    tick();

    // Test 3: lsu write with no response -> timeout error, then late response.
    lsu_req_i = 1; lsu_addr_i = 32'h200; lsu_we_i = 1; lsu_wdata_i = 32'h12345678; lsu_be_i = 4'hF;
    mem_gnt_i = 1;
    tick();
    @(negedge clk_i);
    chk("t3_mem_we", mem_we_o, 1'b1);
    chk("t3_mem_wdata", mem_wdata_o, 32'h12345678);
    chk("t3_lsu_gnt", lsu_gnt_o, 1'b1);
    tick();
    lsu_req_i = 0; lsu_we_i = 0; mem_gnt_i = 0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (lsu_rvalid_o) begin
        k = i;
        chk("t3_lsu_err", lsu_err_o, 1'b1);
        break;
      end
    end
    chk("t3_timeout_lat", k, TIMEOUT - 1);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    @(negedge clk_i);
    chk("t3_late", late_rsp_o, 1'b1);
    tick();

    // Test 4: ifu fetch with the address phase stalled for 5 cycles.
    ifu_req_i = 1; ifu_addr_i = 32'h480;
    tick();
    stable_cnt = 0; gcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_addr_o == 32'h480) stable_cnt++;
      gcnt += int'(ifu_gnt_o);
      tick();
    end
    mem_gnt_i = 1;
    @(negedge clk_i);
    gcnt += int'(ifu_gnt_o);
    tick();
    mem_gnt_i = 0; ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    gcnt += int'(ifu_gnt_o);
    chk("t4_ifu_rvalid", ifu_rvalid_o, 1'b1);
    chk("t4_rdata", rdata_o, 32'hCAFEF00D);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    chk("t4_stable", stable_cnt, 5);
    chk("t4_gnt_pulses", gcnt, 1);
    tick();

    // Test 5: reset during the response phase, then a normal dbg read.
    dbg_req_i = 1; dbg_addr_i = 32'hD40; dbg_we_i = 0; dbg_be_i = 4'hF; mem_gnt_i = 1;
    tick();
    tick();
    dbg_req_i = 0; mem_gnt_i = 0;
    #1;
    rst_ni = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1;
    chk("t5_rst_rvalid", dbg_rvalid_o, 1'b0);
    chk("t5_rst_mem_req", mem_req_o, 1'b0);
    chk("t5_rst_rdata", rdata_o, 32'h0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    tick();
    rst_ni = 1;
    tick();
    dbg_req_i = 1; dbg_addr_i = 32'hD80; mem_gnt_i = 1;
    tick();
    @(negedge clk_i);
    chk("t5_dbg_gnt", dbg_gnt_o, 1'b1);
    chk("t5_mem_addr", mem_addr_o, 32'hD80);
    tick();
    dbg_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h600DF00D;
    @(negedge clk_i);
    chk("t5_dbg_rvalid", dbg_rvalid_o, 1'b1);
    chk("t5_rdata", rdata_o, 32'h600DF00D);
    chk("t5_late", late_rsp_o, 1'b0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
